// File: rtl/battleship_game_ctrl_if.sv
// Cell-read port between the game controller and the VGA colour selector.
// The selector drives (board, row, col) and gets the 3-bit cell code back in the same cycle.
interface battleship_game_ctrl_if;
  logic       rd_pc;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [2:0] rd_state;

  modport master (output rd_pc, output rd_row, output rd_col, input rd_state);
  modport slave  (input rd_pc, input rd_row, input rd_col, output rd_state);
endinterface

// File: rtl/battleship_game_ctrl.sv
// Turn sequencer for the 5x5 two-board battleship game: boards, cursor, turn FSM,
// PC shot generator, win detection and a combinational cell-read port.
//
// state         | meaning
// --------------+------------------------------------------------------------
// S_IDLE        | waiting for start after reset
// S_CHECK       | one cycle: win test, then dispatch on turn
// S_PLAYER_TURN | cursor moves, fire or timeout hands the turn to the PC
// S_PC_WAIT     | PC think delay
// S_PC_SEEK     | walk from the random index to the next unshot player cell
// S_PC_FIRE     | commit the PC shot, hand the turn back
// S_WIN_PLAYER  | game over, player won
// S_WIN_PC      | game over, PC won
module battleship_game_ctrl #(
  parameter logic [29:0] TIMEOUT_CYCLES  = 30'd750_000_000,
  parameter logic [29:0] PC_DELAY_CYCLES = 30'd50_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [24:0]                 player_ships,
  input  logic [24:0]                 pc_ships,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_fire,
  battleship_game_ctrl_if.slave       rd_if,
  output logic [2:0]                  cursor_row,
  output logic [2:0]                  cursor_col,
  output logic                        turn,
  output logic                        shot_valid,
  output logic                        game_over,
  output logic                        winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PLAYER_TURN, S_PC_WAIT,
    S_PC_SEEK, S_PC_FIRE, S_WIN_PLAYER, S_WIN_PC
  } state_t;

  localparam logic [2:0] CELL_MAR         = 3'b000;
  localparam logic [2:0] CELL_D_FALLIDO   = 3'b001;
  localparam logic [2:0] CELL_B_DESTRUIDO = 3'b010;
  localparam logic [2:0] CELL_D_ACERTADO  = 3'b011;
  localparam logic [2:0] CELL_SELECTED    = 3'b100;
  localparam logic [2:0] CELL_NO_ACTIVO   = 3'b101;

  function automatic logic [4:0] popcount25(input logic [24:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 25; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [4:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return ({2'b00, r} << 2) + {2'b00, r} + {2'b00, c};
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
  endfunction

  state_t      state_q, state_d;
  logic [24:0] player_ships_q, player_ships_d;
  logic [24:0] pc_ships_q, pc_ships_d;
  logic [24:0] player_shot_q, player_shot_d;
  logic [24:0] pc_shot_q, pc_shot_d;
  logic [4:0]  player_cnt_q, player_cnt_d;
  logic [4:0]  pc_cnt_q, pc_cnt_d;
  logic [4:0]  player_hits_q, player_hits_d;
  logic [4:0]  pc_hits_q, pc_hits_d;
  logic [2:0]  cur_row_q, cur_row_d;
  logic [2:0]  cur_col_q, cur_col_d;
  logic        turn_q, turn_d;
  logic        shot_valid_q, shot_valid_d;
  logic [29:0] timer_q, timer_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [4:0]  seek_idx_q, seek_idx_d;

  logic [4:0]  cur_idx;
  logic [4:0]  lfsr_idx;

  assign cur_idx  = cell_idx(cur_row_q, cur_col_q);
  assign lfsr_idx = (lfsr_q[4:0] >= 5'd25) ? lfsr_q[4:0] - 5'd25 : lfsr_q[4:0];

  always_comb begin
    state_d        = state_q;
    player_ships_d = player_ships_q;
    pc_ships_d     = pc_ships_q;
    player_shot_d  = player_shot_q;
    pc_shot_d      = pc_shot_q;
    player_cnt_d   = player_cnt_q;
    pc_cnt_d       = pc_cnt_q;
    player_hits_d  = player_hits_q;
    pc_hits_d      = pc_hits_q;
    cur_row_d      = cur_row_q;
    cur_col_d      = cur_col_q;
    turn_d         = turn_q;
    shot_valid_d   = 1'b0;
    timer_d        = timer_q;
    seek_idx_d     = seek_idx_q;
    // x^8+x^6+x^5+x^4+1, shifting left
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_IDLE: ;
      S_CHECK: begin
        timer_d = '0;
        if (pc_hits_q == pc_cnt_q)
          state_d = S_WIN_PLAYER;
        else if (player_hits_q == player_cnt_q)
          state_d = S_WIN_PC;
        else
          state_d = turn_q ? S_PC_WAIT : S_PLAYER_TURN;
      end
      S_PLAYER_TURN: begin
        if (btn_fire && !pc_shot_q[cur_idx]) begin
          pc_shot_d[cur_idx] = 1'b1;
          if (pc_ships_q[cur_idx]) pc_hits_d = pc_hits_q + 5'd1;
          shot_valid_d = 1'b1;
          turn_d       = 1'b1;
          state_d      = S_CHECK;
        end else if (timer_q == TIMEOUT_CYCLES - 30'd1) begin
          turn_d  = 1'b1;
          state_d = S_CHECK;
        end else begin
          timer_d = timer_q + 30'd1;
        end
        // A fire pulse always wins over a simultaneous move.
        if (!btn_fire) begin
          if (btn_up)         cur_row_d = wrap_dec(cur_row_q);
          else if (btn_down)  cur_row_d = wrap_inc(cur_row_q);
          else if (btn_left)  cur_col_d = wrap_dec(cur_col_q);
          else if (btn_right) cur_col_d = wrap_inc(cur_col_q);
        end
      end
      S_PC_WAIT: begin
        if (timer_q == PC_DELAY_CYCLES - 30'd1) begin
          timer_d    = '0;
          seek_idx_d = lfsr_idx;
          state_d    = S_PC_SEEK;
        end else begin
          timer_d = timer_q + 30'd1;
        end
      end
      S_PC_SEEK: begin
        if (player_shot_q[seek_idx_q])
          seek_idx_d = (seek_idx_q == 5'd24) ? 5'd0 : seek_idx_q + 5'd1;
        else
          state_d = S_PC_FIRE;
      end
      S_PC_FIRE: begin
        player_shot_d[seek_idx_q] = 1'b1;
        if (player_ships_q[seek_idx_q]) player_hits_d = player_hits_q + 5'd1;
        shot_valid_d = 1'b1;
        turn_d       = 1'b0;
        state_d      = S_CHECK;
      end
      S_WIN_PLAYER, S_WIN_PC: ;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      player_ships_d = player_ships;
      pc_ships_d     = pc_ships;
      player_cnt_d   = popcount25(player_ships);
      pc_cnt_d       = popcount25(pc_ships);
      player_shot_d  = '0;
      pc_shot_d      = '0;
      player_hits_d  = '0;
      pc_hits_d      = '0;
      timer_d        = '0;
      turn_d         = 1'b0;
      shot_valid_d   = 1'b0;
      state_d        = S_CHECK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      player_ships_q <= '0;
      pc_ships_q     <= '0;
      player_shot_q  <= '0;
      pc_shot_q      <= '0;
      player_cnt_q   <= '0;
      pc_cnt_q       <= '0;
      player_hits_q  <= '0;
      pc_hits_q      <= '0;
      cur_row_q      <= '0;
      cur_col_q      <= '0;
      turn_q         <= 1'b0;
      shot_valid_q   <= 1'b0;
      timer_q        <= '0;
      lfsr_q         <= 8'hA5;
      seek_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      player_ships_q <= player_ships_d;
      pc_ships_q     <= pc_ships_d;
      player_shot_q  <= player_shot_d;
      pc_shot_q      <= pc_shot_d;
      player_cnt_q   <= player_cnt_d;
      pc_cnt_q       <= pc_cnt_d;
      player_hits_q  <= player_hits_d;
      pc_hits_q      <= pc_hits_d;
      cur_row_q      <= cur_row_d;
      cur_col_q      <= cur_col_d;
      turn_q         <= turn_d;
      shot_valid_q   <= shot_valid_d;
      timer_q        <= timer_d;
      lfsr_q         <= lfsr_d;
      seek_idx_q     <= seek_idx_d;
    end
  end

  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign turn       = turn_q;
  assign shot_valid = shot_valid_q;
  assign game_over  = (state_q == S_WIN_PLAYER) || (state_q == S_WIN_PC);
  assign winner     = (state_q == S_WIN_PC);

  logic [4:0] rd_idx;
  logic       rd_shot;
  logic       rd_ship;

  // Once the game is over the loser's ships are all hit, so any unshot ship left is a survivor.
  always_comb begin
    rd_idx  = cell_idx(rd_if.rd_row, rd_if.rd_col);
    rd_shot = rd_if.rd_pc ? pc_shot_q[rd_idx] : player_shot_q[rd_idx];
    rd_ship = rd_if.rd_pc ? pc_ships_q[rd_idx] : player_ships_q[rd_idx];
    rd_if.rd_state = CELL_MAR;
    if (rd_if.rd_row > 3'd4 || rd_if.rd_col > 3'd4)
      rd_if.rd_state = CELL_NO_ACTIVO;
    else if (rd_shot && rd_ship)
      rd_if.rd_state = CELL_D_ACERTADO;
    else if (rd_shot)
      rd_if.rd_state = CELL_D_FALLIDO;
    else if (game_over && rd_ship)
      rd_if.rd_state = CELL_B_DESTRUIDO;
    else if (state_q == S_PLAYER_TURN && rd_if.rd_pc &&
             rd_if.rd_row == cur_row_q && rd_if.rd_col == cur_col_q)
      rd_if.rd_state = CELL_SELECTED;
  end

endmodule
